// File: rtl/chocorol_fetch.sv
// Instruction sequencer feeding the ChocoRol 20-bit datapath over a valid/ready handshake.
// Define CHOCOROL_FETCH_LOOP_EN to wrap PC from PROF-1 back to 0 instead of halting at end of memory.
module chocorol_fetch #(
    parameter int PROF = 16,
    parameter int AW   = $clog2(PROF)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          Carga,
    input  logic [AW-1:0] DirCarga,
    input  logic [19:0]   DatoCarga,
    input  logic          Inicio,
    output logic [19:0]   Instruccion,
    output logic          Valido,
    input  logic          Listo,
    output logic [AW-1:0] PC,
    output logic          Ocupado,
    output logic          Fin
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [19:0] HALT_WORD = 20'hFFFFF;
`ifndef CHOCOROL_FETCH_LOOP_EN
    localparam logic [AW-1:0] LAST_ADDR = AW'(PROF - 1);
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [19:0]   instr_q, instr_d;
    logic          vld_q, vld_d;
    logic [19:0]   mem_q [PROF];
    logic [19:0]   word;
    logic          take;

    // Program memory has no reset so a loaded program survives rst_n.
    always_ff @(posedge clk) begin
        if (Carga && state_q != S_RUN) begin
            mem_q[DirCarga] <= DatoCarga;
        end
    end

    assign word = mem_q[pc_q];
    assign take = !vld_q || Listo;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        case (state_q)
            S_RUN: begin
                if (take) begin
                    if (word == HALT_WORD) begin
                        vld_d   = 1'b0;
                        state_d = S_HALT;
                    end else begin
                        instr_d = word;
                        vld_d   = 1'b1;
`ifdef CHOCOROL_FETCH_LOOP_EN
                        pc_d    = pc_q + 1'b1;
`else
                        if (pc_q == LAST_ADDR) begin
                            state_d = S_HALT;
                        end else begin
                            pc_d = pc_q + 1'b1;
                        end
`endif
                    end
                end
            end
            S_IDLE, S_HALT: begin
                // A word left pending at end of memory still drains in HALT.
                if (vld_q && Listo) begin
                    vld_d = 1'b0;
                end
                if (Inicio && !vld_q) begin
                    pc_d    = '0;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
        end
    end

    assign Instruccion = instr_q;
    assign Valido      = vld_q;
    assign PC          = pc_q;
    assign Ocupado     = (state_q == S_RUN);
    assign Fin         = (state_q == S_HALT);

endmodule
